// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   MDU_WIDTH    operand width (32)
//   MDU_ITER     iterations per multiply/divide (32)
//   mdu_op_e     Op encodings: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   mdu_state_e  FSM states IDLE / RUN / DONE
//   Helper functions for operand classification and conditional negation.
// ---------------------------------------------------------------------------
package mdu_pkg;

   localparam int MDU_WIDTH = 32;
   localparam int MDU_ITER  = 32;
   localparam int MDU_CNT_W = 6;

   // Counter value reached after the last iteration has been applied.
   localparam logic [MDU_CNT_W-1:0] MDU_LAST_CNT = MDU_CNT_W'(MDU_ITER);

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } mdu_state_e;

   // Bit 0 of Op selects unsigned; bit 1 selects divide.
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic [MDU_WIDTH-1:0] cond_neg(input logic [MDU_WIDTH-1:0] v,
                                                     input logic               neg);
      return neg ? (~v + {{(MDU_WIDTH-1){1'b0}}, 1'b1}) : v;
   endfunction

   // Magnitude of an operand; 0x80000000 maps to 2^31, which fits unsigned.
   function automatic logic [MDU_WIDTH-1:0] mdu_abs(input logic [MDU_WIDTH-1:0] v,
                                                    input logic               is_signed);
      return cond_neg(v, is_signed & v[MDU_WIDTH-1]);
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// ---------------------------------------------------------------------------
// mdu_div_step -- one combinational restoring-division iteration.
// The partial remainder is shifted left pulling in the next dividend bit
// (MSB of the quotient register); the divisor is subtracted and the result
// kept only when no borrow occurs. The quotient bit enters at the LSB.
//   rem_in   partial remainder (always < divisor)
//   quo_in   quotient register (remaining dividend bits in the upper part)
//   divisor  divisor magnitude
//   rem_out  next partial remainder
//   quo_out  next quotient register
// ---------------------------------------------------------------------------
module mdu_div_step
   import mdu_pkg::*;
(
   input  logic [MDU_WIDTH-1:0] rem_in,
   input  logic [MDU_WIDTH-1:0] quo_in,
   input  logic [MDU_WIDTH-1:0] divisor,
   output logic [MDU_WIDTH-1:0] rem_out,
   output logic [MDU_WIDTH-1:0] quo_out
);

   logic [MDU_WIDTH:0] shifted;
   logic [MDU_WIDTH:0] diff;
   logic               borrow;

   assign shifted = {rem_in, quo_in[MDU_WIDTH-1]};
   assign diff    = shifted - {1'b0, divisor};
   assign borrow  = diff[MDU_WIDTH];

   // Since rem_in < divisor, shifted < 2*divisor, so the kept value fits.
   assign rem_out = borrow ? shifted[MDU_WIDTH-1:0] : diff[MDU_WIDTH-1:0];
   assign quo_out = {quo_in[MDU_WIDTH-2:0], ~borrow};

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit -- iterative 32x32 multiply / 32/32 divide unit for HiLo.
// Multiply: shift-add, divide: restoring, one iteration per cycle on operand
// magnitudes, with the sign fixed up in a final cycle. Start sampled at edge N
// gives Done in the cycle after edge N+33. Divide by zero skips RUN.
// Optional feature: define MDU_DIV_EN to build the divide datapath; without
// it DIV/DIVU complete at once with HiLoEn=0 and HiLo unchanged.
//   Clk        clock, rising edge
//   Rst        asynchronous active-low reset
//   Start      request, accepted only in IDLE
//   Op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B       operands (multiplicand/dividend, multiplier/divisor)
//   Busy       high in RUN and DONE
//   Done       one-cycle completion pulse
//   HiLoEn     HiLo write enable, with Done
//   HiLoWrite  {Hi, Lo} result, held between operations
//   DivByZero  pulse with Done when a divide had B==0
// ---------------------------------------------------------------------------
module mult_div_unit
   import mdu_pkg::*;
(
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   Start,
   input  logic [1:0]             Op,
   input  logic [MDU_WIDTH-1:0]   A,
   input  logic [MDU_WIDTH-1:0]   B,
   output logic                   Busy,
   output logic                   Done,
   output logic                   HiLoEn,
   output logic [2*MDU_WIDTH-1:0] HiLoWrite,
   output logic                   DivByZero
);

   localparam int W = MDU_WIDTH;

   mdu_state_e           state;
   logic [MDU_CNT_W-1:0] cnt;
   logic [W-1:0]         opnd_q;     // multiplicand or divisor magnitude
   logic [2*W-1:0]       acc;        // {hi, lo}: product or {remainder, quotient}
   logic [2*W-1:0]       hilo_q;
   logic                 neg_res_q;  // negate product / quotient
   logic                 hilo_en_q;

   logic                 op_signed;
   logic                 a_neg;
   logic                 b_neg;
   logic [W-1:0]         mag_a;
   logic [W-1:0]         mag_b;
   logic [W:0]           mul_sum;
   logic [2*W-1:0]       mul_next;
   logic [2*W-1:0]       prod_fix;
   logic [2*W-1:0]       acc_next;
   logic [2*W-1:0]       result_final;
   logic                 start_skip;  // Start that goes straight to DONE
   logic [2*W-1:0]       skip_hilo;
   logic                 skip_en;

   assign op_signed = op_is_signed(Op);
   assign a_neg     = op_signed & A[W-1];
   assign b_neg     = op_signed & B[W-1];
   assign mag_a     = mdu_abs(A, op_signed);
   assign mag_b     = mdu_abs(B, op_signed);

   // Shift-add: lo holds the remaining multiplier bits; the carry out of the
   // hi addition shifts back into the hi half.
   assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
   assign mul_next = {mul_sum, acc[W-1:1]};
   assign prod_fix = neg_res_q ? (~acc + 64'd1) : acc;

`ifdef MDU_DIV_EN
   logic         is_div_q;
   logic         neg_rem_q;  // remainder takes the sign of A
   logic         dbz_q;
   logic [W-1:0] rem_step;
   logic [W-1:0] quo_step;

   mdu_div_step u_div_step (
      .rem_in  (acc[2*W-1:W]),
      .quo_in  (acc[W-1:0]),
      .divisor (opnd_q),
      .rem_out (rem_step),
      .quo_out (quo_step)
   );

   assign acc_next     = is_div_q ? {rem_step, quo_step} : mul_next;
   assign result_final = is_div_q ? {cond_neg(acc[2*W-1:W], neg_rem_q),
                                     cond_neg(acc[W-1:0],   neg_res_q)}
                                  : prod_fix;
   assign start_skip   = op_is_div(Op) && (B == '0);
   assign skip_hilo    = {A, {W{1'b1}}};
   assign skip_en      = 1'b1;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         is_div_q  <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
      end else if (state == ST_IDLE && Start) begin
         is_div_q  <= op_is_div(Op);
         neg_rem_q <= a_neg;
         dbz_q     <= op_is_div(Op) && (B == '0);
      end
   end

   assign DivByZero = (state == ST_DONE) & dbz_q;
`else
   assign acc_next     = mul_next;
   assign result_final = prod_fix;
   assign start_skip   = op_is_div(Op);
   assign skip_hilo    = hilo_q;
   assign skip_en      = 1'b0;
   assign DivByZero    = 1'b0;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; all state (no memories here) is cleared by reset, so an
   // abort mid-RUN leaves nothing that could later complete.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         opnd_q    <= '0;
         acc       <= '0;
         hilo_q    <= '0;
         neg_res_q <= 1'b0;
         hilo_en_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  cnt       <= '0;
                  neg_res_q <= a_neg ^ b_neg;
                  if (start_skip) begin
                     hilo_q    <= skip_hilo;
                     hilo_en_q <= skip_en;
                     state     <= ST_DONE;
                  end else begin
                     // Divide iterates over the dividend, multiply over the multiplier.
                     acc    <= {{W{1'b0}}, (op_is_div(Op) ? mag_a : mag_b)};
                     opnd_q <= op_is_div(Op) ? mag_b : mag_a;
                     state  <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               // 32 iteration cycles, then one cycle applying the sign fix-up.
               if (cnt == MDU_LAST_CNT) begin
                  hilo_q    <= result_final;
                  hilo_en_q <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  acc <= acc_next;
                  cnt <= cnt + MDU_CNT_W'(1);
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign Busy      = (state != ST_IDLE);
   assign Done      = (state == ST_DONE);
   assign HiLoEn    = (state == ST_DONE) & hilo_en_q;
   assign HiLoWrite = hilo_q;

endmodule
